// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
package regfile_pkg;

   typedef enum logic [0:0] {
      IDLE,
      CLEAR
   } rf_state_t;

   localparam int unsigned RF_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sweep-clear sequencer: owns the IDLE/CLEAR state, the sweep counter and the
// write accept/drop decision for the register file.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we3,
   input  logic [ADDR_W-1:0] wa3,
   input  logic              clr_start,
   output logic              clr_en,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              wr_ok,
   output logic              wr_drop,
   output logic              busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              drop_q, drop_d;
   logic              wr_req;

   assign wr_req = we3 && (wa3 != ZERO_ADDR);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_en   = 1'b0;
      clr_addr = cnt_q;
      wr_ok    = 1'b0;
      drop_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            wr_ok  = wr_req && !clr_start;
            drop_d = wr_req && clr_start;
            if (clr_start) begin
               state_d = CLEAR;
               cnt_d   = ADDR_W'(1);
            end
         end
         CLEAR: begin
            clr_en = 1'b1;
            drop_d = wr_req;
            // Full-range counter wraps back to 0 as the last entry is cleared.
            cnt_d  = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   assign busy    = (state_q == CLEAR);
   assign wr_drop = drop_q;

endmodule

// File: rtl/regfile_param.sv
// DEPTH x DATA_W register file, one write and two read ports, R0 reads zero.
// Optional same-cycle write forwarding when WRITE_BYPASS_EN is defined.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we3,
   input  logic [ADDR_W-1:0] wa3,
   input  logic [DATA_W-1:0] wd3,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              clr_start,
   output logic              busy,
   output logic              wr_drop
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic              clr_en;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_ok;
   logic [DATA_W-1:0] rd1_arr, rd2_arr;

   regfile_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .we3       (we3),
      .wa3       (wa3),
      .clr_start (clr_start),
      .clr_en    (clr_en),
      .clr_addr  (clr_addr),
      .wr_ok     (wr_ok),
      .wr_drop   (wr_drop),
      .busy      (busy)
   );

   // wr_ok is only ever raised in IDLE, so it never collides with a sweep write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_ok) begin
         regs_q[wa3] <= wd3;
      end else if (clr_en) begin
         regs_q[clr_addr] <= '0;
      end
   end

   assign rd1_arr = (ra1 == ZERO_ADDR) ? '0 : regs_q[ra1];
   assign rd2_arr = (ra2 == ZERO_ADDR) ? '0 : regs_q[ra2];

`ifdef WRITE_BYPASS_EN
   assign rd1 = (wr_ok && (ra1 == wa3)) ? wd3 : rd1_arr;
   assign rd2 = (wr_ok && (ra2 == wa3)) ? wd3 : rd2_arr;
`else
   assign rd1 = rd1_arr;
   assign rd2 = rd2_arr;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (default 8-bit x 8 entries).
module tb_regfile_param;

   logic       clk;
   logic       rst_n;
   logic       we3;
   logic [2:0] wa3;
   logic [7:0] wd3;
   logic [2:0] ra1;
   logic [2:0] ra2;
   logic [7:0] rd1;
   logic [7:0] rd2;
   logic       clr_start;
   logic       busy;
   logic       wr_drop;

   int errors = 0;
   int checks = 0;

   regfile_param #(
      .DATA_W (8),
      .ADDR_W (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .ra1       (ra1),
      .ra2       (ra2),
      .rd1       (rd1),
      .rd2       (rd2),
      .clr_start (clr_start),
      .busy      (busy),
      .wr_drop   (wr_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      we3 = 1'b1;
      wa3 = a;
      wd3 = d;
      tick();
      we3 = 1'b0;
   endtask

   task automatic read1(input logic [2:0] a, input string tag, input logic [7:0] exp);
      ra1 = a;
      #1;
      check(tag, {24'd0, rd1}, {24'd0, exp});
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      logic [7:0] exp_byp;
      rst_n = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0;
      ra1 = '0; ra2 = '0; clr_start = 1'b0;
      #12;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_drop", {31'd0, wr_drop}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: reset contents and basic writes
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i);
         ra2 = 3'(i);
         #1;
         check("reset_rd1", {24'd0, rd1}, 32'd0);
         check("reset_rd2", {24'd0, rd2}, 32'd0);
      end
      wr(3'd3, 8'hA5);
      wr(3'd7, 8'h3C);
      ra1 = 3'd3; ra2 = 3'd7;
      #1;
      check("wr_r3", {24'd0, rd1}, 32'hA5);
      check("wr_r7", {24'd0, rd2}, 32'h3C);
      ra2 = 3'd3;
      #1;
      check("same_addr", {24'd0, rd2}, 32'hA5);

      // 2: writes to R0 are ignored silently
      wr(3'd0, 8'hFF);
      read1(3'd0, "r0_zero", 8'h00);
      check("r0_no_drop", {31'd0, wr_drop}, 32'd0);

      // 3: fill then sweep clear
      for (int i = 1; i < 8; i++) begin
         wr(3'(i), 8'(i * 8'h11));
      end
      read1(3'd6, "fill_r6", 8'h66);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         n++;
         if (n == 2) begin
            read1(3'd1, "sweep_r1", 8'h00);
            read1(3'd7, "sweep_r7", 8'h77);
         end
         tick();
      end
      check("busy_len", n, 32'd7);
      for (int i = 1; i < 8; i++) begin
         read1(3'(i), "swept", 8'h00);
      end

      // 4: write while sweeping is dropped; restart request ignored
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      n = 0;
      tick(); n++;
      tick(); n++;
      we3 = 1'b1; wa3 = 3'd5; wd3 = 8'h99;
      tick(); n++;
      we3 = 1'b0;
      check("drop_pulse", {31'd0, wr_drop}, 32'd1);
      tick(); n++;
      check("drop_one_cycle", {31'd0, wr_drop}, 32'd0);
      clr_start = 1'b1;
      tick(); n++;
      clr_start = 1'b0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      check("busy_len_restart", n, 32'd7);
      read1(3'd5, "r5_dropped", 8'h00);

      // 5: clr_start and write in the same IDLE cycle
      wr(3'd2, 8'h07);
      clr_start = 1'b1;
      we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h42;
      tick();
      clr_start = 1'b0;
      we3 = 1'b0;
      check("same_cycle_drop", {31'd0, wr_drop}, 32'd1);
      check("same_cycle_busy", {31'd0, busy}, 32'd1);
      read1(3'd2, "r2_not_written", 8'h07);
      wait_idle("idle_after_5");
      read1(3'd2, "r2_cleared", 8'h00);

      // 6: write-first forwarding (or not)
      wr(3'd4, 8'h01);
`ifdef WRITE_BYPASS_EN
      exp_byp = 8'h5A;
`else
      exp_byp = 8'h01;
`endif
      we3 = 1'b1; wa3 = 3'd4; wd3 = 8'h5A; ra1 = 3'd4; ra2 = 3'd4;
      #1;
      check("bypass_rd1", {24'd0, rd1}, {24'd0, exp_byp});
      check("bypass_rd2", {24'd0, rd2}, {24'd0, exp_byp});
      tick();
      we3 = 1'b0;
      read1(3'd4, "after_wr_r4", 8'h5A);

      // async reset mid-sweep
      wr(3'd6, 8'h66);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      for (int i = 1; i < 8; i++) begin
         read1(3'(i), "rst_clear", 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      check("rst_stays_idle", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
